// File: rtl/shared_val_arbiter.sv
// Round-robin arbiter that sequences write access to a shared value register.
// It exposes the register as the full word, bit 0 and the upper half.
module shared_val_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     wr_mode,
    input  logic [WIDTH*NUM_REQ-1:0] wr_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     done,
    output logic                     busy,
    output logic [WIDTH-1:0]         val_out,
    output logic                     bit0_out,
    output logic [WIDTH/2-1:0]       hi_out,
    output logic                     val_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, UPDATE, ACK} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] pick;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] val;
    int               cand;

    // Scan offsets high to low so the requester closest to ptr is assigned last and wins.
    always_comb begin
        pick = ptr;
        cand = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req[cand]) pick = IDX_W'(cand);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = GRANT;
            GRANT:   state_nxt = UPDATE;
            UPDATE:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= 1'b0;
            val       <= '0;
            val_valid <= 1'b0;
            ptr       <= '0;
            win       <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == UPDATE);
            case (state)
                IDLE: begin
                    if (|req) begin
                        win <= pick;
                        gnt <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    end
                end
                GRANT: begin
                    ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                end
                UPDATE: begin
                    gnt <= '0;
                    case (mode_q)
                        2'b00:   val <= data_q;
                        2'b01:   val[WIDTH-1:WIDTH/2] <= data_q[WIDTH-1:WIDTH/2];
                        2'b10:   val[0] <= data_q[0];
                        default: ;
                    endcase
                end
                ACK: begin
                    if (mode_q != 2'b11) val_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Winner's mode and data are captured once; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (state == GRANT) begin
            mode_q <= wr_mode[2*win +: 2];
            data_q <= wr_data[WIDTH*win +: WIDTH];
        end
    end

    assign busy     = (state != IDLE);
    assign val_out  = val;
    assign bit0_out = val[0];
    assign hi_out   = val[WIDTH-1:WIDTH/2];

endmodule

// File: tb/tb_shared_val_arbiter.sv
// Directed bench for shared_val_arbiter with hand-computed expected values.
module tb_shared_val_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [7:0]   wr_mode;
    logic [127:0] wr_data;
    logic [3:0]   gnt;
    logic         done;
    logic         busy;
    logic [31:0]  val_out;
    logic         bit0_out;
    logic [15:0]  hi_out;
    logic         val_valid;

    int checks   = 0;
    int failures = 0;

    shared_val_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_mode(wr_mode), .wr_data(wr_data),
        .gnt(gnt), .done(done), .busy(busy), .val_out(val_out),
        .bit0_out(bit0_out), .hi_out(hi_out), .val_valid(val_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int r, input logic [1:0] m, input logic [31:0] d,
                       input logic [31:0] exp_val, input logic exp_valid);
        logic [3:0] g;
        g = 4'b0001 << r;
        wr_mode[2*r +: 2]  = m;
        wr_data[32*r +: 32] = d;
        req[r] = 1'b1;
        tick();
        chk("grant_first", 32'(gnt), 32'(g));
        chk("busy_grant", 32'(busy), 32'd1);
        tick();
        chk("grant_second", 32'(gnt), 32'(g));
        chk("done_early", 32'(done), 32'd0);
        req[r] = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("gnt_ack", 32'(gnt), 32'd0);
        chk("val", val_out, exp_val);
        chk("hi", 32'(hi_out), 32'(exp_val[31:16]));
        chk("bit0", 32'(bit0_out), 32'(exp_val[0]));
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("val_valid", 32'(val_valid), 32'(exp_valid));
    endtask

    initial begin
        logic [3:0]  order    [4];
        logic [31:0] order_val[4];
        order     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        order_val = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

        rst_n   = 1'b0;
        req     = 4'b0000;
        wr_mode = '0;
        wr_data = '0;
        tick();
        tick();
        chk("rst_val", val_out, 32'h0);
        chk("rst_bit0", 32'(bit0_out), 32'd0);
        chk("rst_hi", 32'(hi_out), 32'h0000);
        chk("rst_valid", 32'(val_valid), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Probe from reset: nothing written, val_valid stays low.
        txn(2, 2'b11, 32'hDEADBEEF, 32'h00000000, 1'b0);
        txn(0, 2'b00, 32'h87654321, 32'h87654321, 1'b1);
        txn(1, 2'b01, 32'hABCD0000, 32'hABCD4321, 1'b1);
        chk("hi_abcd", 32'(hi_out), 32'h0000ABCD);
        txn(2, 2'b10, 32'h00000000, 32'hABCD4320, 1'b1);
        chk("bit0_cleared", 32'(bit0_out), 32'd0);

        // Fresh reset so the pointer starts at 0 for the rotation check.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        wr_mode = 8'b00_00_00_00;
        wr_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        req     = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(order[k]));
            tick();
            tick();
            chk("rr_done", 32'(done), 32'd1);
            chk("rr_val", val_out, order_val[k]);
            req[k] = 1'b0;
            tick();
        end

        wr_data[31:0]  = 32'hA0A0A0A0;
        wr_data[95:64] = 32'hC2C2C2C2;
        req = 4'b0101;
        tick();
        chk("pair_gnt0", 32'(gnt), 32'h1);
        tick();
        tick();
        chk("pair_done0", 32'(done), 32'd1);
        chk("pair_val0", val_out, 32'hA0A0A0A0);
        req[0] = 1'b0;
        tick();
        tick();
        chk("pair_gnt2", 32'(gnt), 32'h4);
        tick();
        tick();
        chk("pair_done2", 32'(done), 32'd1);
        chk("pair_val2", val_out, 32'hC2C2C2C2);
        req[2] = 1'b0;
        tick();

        txn(3, 2'b00, 32'h12345678, 32'h12345678, 1'b1);
        txn(3, 2'b11, 32'hFFFFFFFF, 32'h12345678, 1'b1);

        // Abort a full write during UPDATE.
        wr_mode[3:2]  = 2'b00;
        wr_data[63:32] = 32'hFFFFFFFF;
        req = 4'b0010;
        tick();
        tick();
        chk("abort_in_update", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_val", val_out, 32'h0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_valid", 32'(val_valid), 32'd0);
        req = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick();
        chk("abort_no_done1", 32'(done), 32'd0);
        tick();
        chk("abort_no_done2", 32'(done), 32'd0);
        chk("abort_val_hold", val_out, 32'h0);

        // Pointer back at 0: requester 1 beats requester 3.
        wr_mode = 8'b00_00_00_00;
        wr_data[63:32]  = 32'h00000055;
        wr_data[127:96] = 32'h00000077;
        req = 4'b1010;
        tick();
        chk("ptr_reset_gnt", 32'(gnt), 32'h2);
        tick();
        req = 4'b0000;
        tick();
        chk("ptr_reset_done", 32'(done), 32'd1);
        chk("ptr_reset_val", val_out, 32'h00000055);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
